// File: rtl/jt49_pkg.sv
// rtl/jt49_pkg.sv - shared helpers for the JT49 moving-average filter
package jt49_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int unsigned clamp_win(input int unsigned w, input int unsigned depth);
    return (w > depth) ? depth : w;
  endfunction

  // Sign-extends the low w bits of v to 64 bits; callers size-cast the result.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] sb;
    logic [63:0] m;
    sb = 64'd1 << (w - 1);
    m  = (64'd1 << w) - 64'd1;
    return ((v & m) ^ sb) - sb;
  endfunction

endpackage

// File: rtl/jt49_mave_ram.sv
// rtl/jt49_mave_ram.sv - simple dual-port read-first history RAM
module jt49_mave_ram #(
  parameter int DW    = 8,
  parameter int WORDS = 768,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [WORDS];

  // Both updates are non-blocking, so a colliding read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/jt49_mave_mc.sv
// rtl/jt49_mave_mc.sv - multi-channel time-multiplexed moving-average filter
module jt49_mave_mc #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int CH    = 3,
  parameter int CW    = 2,
  parameter int WW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] din_ch,
  input  logic [WW-1:0] win,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] dout_ch,
  output logic          dout_valid,
  output logic          busy
);
  import jt49_pkg::*;

  localparam int ACW   = DW + DEPTH;
  localparam int WORDS = CH << DEPTH;
  localparam int RAW   = $clog2(WORDS);
  localparam logic [RAW-1:0] CLR_LAST = RAW'(WORDS - 1);
  localparam logic [CW:0]    CH_LIM   = (CW + 1)'(CH);

  state_t                state_q, state_d;
  logic [WW-1:0]         win_q;
  logic [RAW-1:0]        clr_q;
  logic [DEPTH-1:0]      wptr_q [1<<CW];
  logic signed [ACW-1:0] acc_q  [1<<CW];
  logic                  s1_valid_q;
  logic [CW-1:0]         s1_ch_q;
  logic [DW-1:0]         s1_din_q;
  logic [DW-1:0]         dout_q;
  logic [CW-1:0]         dout_ch_q;
  logic                  dout_valid_q;

  logic [WW-1:0]         win_c;
  logic                  clearing, ch_ok, win_chg, accept;
  logic [DEPTH-1:0]      wptr_cur, rptr;
  logic                  ram_we;
  logic [RAW-1:0]        ram_waddr, ram_raddr;
  logic [DW-1:0]         ram_wdata, ram_rdata;
  logic [DW:0]           diff;
  logic signed [ACW-1:0] acc_new;
  logic [DW-1:0]         dout_new;

  // Stage 0: address generation; 1 << DEPTH wraps to 0, making read == write.
  always_comb begin
    win_c     = WW'(clamp_win(32'(win), DEPTH));
    clearing  = (state_q == ST_CLEAR);
    ch_ok     = ({1'b0, din_ch} < CH_LIM);
    win_chg   = (state_q == ST_RUN) && (win_c != win_q);
    accept    = (state_q == ST_RUN) && cen && ch_ok && !win_chg;
    wptr_cur  = wptr_q[din_ch];
    rptr      = wptr_cur - (DEPTH'(1) << win_q);
    ram_we    = clearing || accept;
    ram_waddr = clearing ? clr_q : RAW'({din_ch, wptr_cur});
    ram_wdata = clearing ? '0 : din;
    ram_raddr = RAW'({din_ch, rptr});
  end

  // Stage 1: the accumulator updates in a single clk, so a back-to-back
  // sample on the same channel always reads the freshly written value.
  always_comb begin
    diff     = (DW + 1)'(sext(64'(s1_din_q), DW) - sext(64'(ram_rdata), DW));
    acc_new  = acc_q[s1_ch_q] + ACW'(sext(64'(diff), DW + 1));
    dout_new = DW'(acc_new >>> win_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_q == CLR_LAST) state_d = ST_RUN;
      ST_RUN:   if (win_chg)           state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= win_c;
      clr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_ch_q      <= '0;
      s1_din_q     <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < (1 << CW); i++) begin
        wptr_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      s1_valid_q   <= accept;
      s1_ch_q      <= din_ch;
      s1_din_q     <= din;
      dout_valid_q <= s1_valid_q && !win_chg;
      if (s1_valid_q && !win_chg) begin
        acc_q[s1_ch_q] <= acc_new;
        dout_q         <= dout_new;
        dout_ch_q      <= s1_ch_q;
      end
      if (accept) begin
        wptr_q[din_ch] <= wptr_cur + DEPTH'(1);
      end
      if (win_chg) begin
        win_q <= win_c;
      end
      if (clearing) begin
        clr_q <= (clr_q == CLR_LAST) ? '0 : clr_q + RAW'(1);
        for (int i = 0; i < (1 << CW); i++) begin
          wptr_q[i] <= '0;
          acc_q[i]  <= '0;
        end
      end else begin
        clr_q <= '0;
      end
    end
  end

  jt49_mave_ram #(
    .DW    (DW),
    .WORDS (WORDS),
    .AW    (RAW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign busy       = clearing;

endmodule

// File: tb/tb_jt49_mave_mc.sv
// tb/tb_jt49_mave_mc.sv - bench for jt49_mave_mc (3-channel and 1-channel instances)
module tb_jt49_mave_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen0, cen1;
  logic [7:0] din0, din1;
  logic [1:0] ch0;
  logic [0:0] ch1;
  logic [3:0] win0, win1;
  logic [7:0] dout0, dout1;
  logic [1:0] dch0;
  logic [0:0] dch1;
  logic       dv0, dv1, busy0, busy1;

  always #5 clk = ~clk;

  jt49_mave_mc #(.DW(8), .DEPTH(8), .CH(3), .CW(2), .WW(4)) dut0 (
    .clk(clk), .rst(rst), .cen(cen0), .din(din0), .din_ch(ch0), .win(win0),
    .dout(dout0), .dout_ch(dch0), .dout_valid(dv0), .busy(busy0)
  );

  jt49_mave_mc #(.DW(8), .DEPTH(8), .CH(1), .CW(1), .WW(4)) dut1 (
    .clk(clk), .rst(rst), .cen(cen1), .din(din1), .din_ch(ch1), .win(win1),
    .dout(dout1), .dout_ch(dch1), .dout_valid(dv1), .busy(busy1)
  );

  typedef struct {
    int due;
    int ch;
    int val;
  } exp_t;

  exp_t eq0[$];
  exp_t eq1[$];
  int   lg00[$];
  int   lg01[$];
  int   lg10[$];
  int   hist[2][8][256];
  int   cnt[2][8];
  int   mwin[2];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int clampw(input int w);
    return (w > 8) ? 8 : w;
  endfunction

  // Average of the last 2^win samples of the channel, zeros before the first.
  function automatic int model_push(input int k, input int ch, input int v);
    int s = 0;
    int n;
    hist[k][ch][cnt[k][ch] % 256] = v;
    cnt[k][ch]++;
    n = 1 << mwin[k];
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = cnt[k][ch] - 1 - i;
      if (idx >= 0) s += hist[k][ch][idx % 256];
    end
    return s >>> mwin[k];
  endfunction

  task automatic model_clear(input int k);
    for (int c = 0; c < 8; c++) cnt[k][c] = 0;
  endtask

  task automatic drop(input int k, input int from);
    if (k == 0) begin
      while (eq0.size() > 0 && eq0[eq0.size()-1].due >= from) void'(eq0.pop_back());
    end else begin
      while (eq1.size() > 0 && eq1[eq1.size()-1].due >= from) void'(eq1.pop_back());
    end
  endtask

  task automatic check_inst(input int k, input logic dv, input int d, input int c);
    exp_t e;
    bit   have = 1'b0;
    if (k == 0 && eq0.size() > 0 && eq0[0].due == cyc) begin e = eq0.pop_front(); have = 1'b1; end
    if (k == 1 && eq1.size() > 0 && eq1[0].due == cyc) begin e = eq1.pop_front(); have = 1'b1; end
    if (have) begin
      chk(k == 0 ? "i0 valid" : "i1 valid", int'(dv), 1);
      chk(k == 0 ? "i0 dout" : "i1 dout", d, e.val);
      chk(k == 0 ? "i0 dout_ch" : "i1 dout_ch", c, e.ch);
    end else begin
      chk(k == 0 ? "i0 idle valid" : "i1 idle valid", int'(dv), 0);
    end
    if (dv) begin
      if (k == 0 && c == 0) lg00.push_back(d);
      if (k == 0 && c == 1) lg01.push_back(d);
      if (k == 1) lg10.push_back(d);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_inst(0, dv0, int'($signed(dout0)), int'(dch0));
      check_inst(1, dv1, int'($signed(dout1)), int'(dch1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int k, input int ch, input int v);
    int e;
    if (k == 0) begin
      cen0 = 1'b1; ch0 = 2'(ch); din0 = 8'(v);
      if (ch < 3) begin e = model_push(0, ch, v); eq0.push_back('{cyc + 2, ch, e}); end
    end else begin
      cen1 = 1'b1; ch1 = 1'(ch); din1 = 8'(v);
      if (ch < 1) begin e = model_push(1, ch, v); eq1.push_back('{cyc + 2, ch, e}); end
    end
    tick();
    if (k == 0) cen0 = 1'b0;
    else cen1 = 1'b0;
  endtask

  task automatic chwin(input int w, input bit with_cen);
    win0 = 4'(w); cen0 = with_cen; ch0 = 2'd0; din0 = 8'd64;
    drop(0, cyc + 1);
    model_clear(0);
    mwin[0] = clampw(w);
    tick();
    cen0 = 1'b0;
  endtask

  task automatic wait_busy(output int n0, output int n1, output int nz);
    n0 = 0; n1 = 0; nz = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy0) n0++;
      if (busy1) n1++;
      if (busy0 && dout0 != 8'd0) nz++;
      if (!busy0 && !busy1) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n0, n1, nz, viol;
    int t2exp[5];
    t2exp = '{16, 32, 48, 64, 64};
    rst = 1'b1; cen0 = 1'b0; din0 = 8'd0; ch0 = 2'd0; win0 = 4'd2;
    cen1 = 1'b0; din1 = 8'd0; ch1 = 1'd0; win1 = 4'd8;
    mwin[0] = 2; mwin[1] = 8;
    model_clear(0); model_clear(1);

    // reset state and initial history clear
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst busy0", int'(busy0), 1);
    chk("rst busy1", int'(busy1), 1);
    chk("rst dout0", int'(dout0), 0);
    chk("rst dout_ch0", int'(dch0), 0);
    chk("rst valid0", int'(dv0), 0);
    rst = 1'b0;
    wait_busy(n0, n1, nz);
    chk("t1 clear len ch3", n0, 768);
    chk("t1 clear len ch1", n1, 256);
    chk("t1 dout zero in clear", nz, 0);

    // win=2, +64 on ch0 every 4th clk
    lg00.delete();
    for (int i = 0; i < 6; i++) begin
      send(0, 0, 64);
      ticks(3);
    end
    ticks(3);
    chk("t2 count", lg00.size(), 6);
    if (lg00.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("t2 literal", lg00[i], t2exp[i]);
    end

    // win=3, alternating -128 / +127 back-to-back
    chwin(3, 1'b0);
    wait_busy(n0, n1, nz);
    chk("t3 clear len", n0, 768);
    lg00.delete(); lg01.delete();
    for (int i = 0; i < 10; i++) begin
      send(0, 0, -128);
      send(0, 1, 127);
    end
    ticks(3);
    chk("t3 count ch0", lg00.size(), 10);
    chk("t3 count ch1", lg01.size(), 10);
    viol = 0;
    for (int i = 1; i < lg00.size(); i++) if (lg00[i] > lg00[i-1]) viol++;
    for (int i = 1; i < lg01.size(); i++) if (lg01[i] < lg01[i-1]) viol++;
    chk("t3 monotonic", viol, 0);
    if (lg00.size() == 10 && lg01.size() == 10) begin
      chk("t3 first ch0", lg00[0], -16);
      chk("t3 first ch1", lg01[0], 15);
      chk("t3 final ch0", lg00[9], -128);
      chk("t3 final ch1", lg01[9], 127);
    end

    // CH=1, win clamped from 15 to 8 (no clear), +1 x256 then 0 x256
    win1 = 4'd15;
    ticks(2);
    chk("t4 clamp no clear", int'(busy1), 0);
    mwin[1] = clampw(15);
    lg10.delete();
    for (int i = 0; i < 512; i++) send(1, 0, (i < 256) ? 1 : 0);
    ticks(3);
    chk("t4 count", lg10.size(), 512);
    if (lg10.size() == 512) begin
      chk("t4 sample255", lg10[254], 0);
      chk("t4 sample256", lg10[255], 1);
      chk("t4 sample257", lg10[256], 0);
      chk("t4 sample512", lg10[511], 0);
    end

    // win change 2 -> 4 with a sample on the same clk
    chwin(2, 1'b0);
    wait_busy(n0, n1, nz);
    chk("t5 clear len a", n0, 768);
    send(0, 0, 64);
    tick();
    send(0, 0, 64);
    ticks(3);
    chwin(4, 1'b1);
    chk("t5 busy next clk", int'(busy0), 1);
    wait_busy(n0, n1, nz);
    chk("t5 clear len b", n0, 768);
    lg00.delete();
    send(0, 0, 64);
    ticks(3);
    chk("t5 restart count", lg00.size(), 1);
    if (lg00.size() == 1) chk("t5 restart value", lg00[0], 4);

    // reset with a full pipeline while an invalid channel is driven
    send(0, 0, 10);
    send(0, 1, 20);
    send(0, 2, 30);
    rst = 1'b1; ch0 = 2'd3; cen0 = 1'b1; din0 = 8'h63;
    drop(0, cyc + 1); drop(1, cyc + 1);
    model_clear(0); model_clear(1);
    mwin[0] = clampw(int'(win0)); mwin[1] = clampw(int'(win1));
    tick();
    rst = 1'b0;
    wait_busy(n0, n1, nz);
    chk("t6 clear len ch3", n0, 768);
    chk("t6 clear len ch1", n1, 256);
    ticks(6);
    cen0 = 1'b0;
    lg00.delete();
    send(0, 0, 64);
    ticks(3);
    chk("t6 post count", lg00.size(), 1);
    if (lg00.size() == 1) chk("t6 post value", lg00[0], 4);
    chk("t6 queue drained", eq0.size() + eq1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
